// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide sequencer: op codes, FSM states, default widths.
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 6;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add multiply step or restoring-divide step.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               div_mode,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
  // Divide:   acc = {remainder, dividend bits / quotient bits}, shifted left each step.
  always_comb begin
    sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    rem_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff   = rem_sh - {1'b0, operand};
    if (div_mode) begin
      if (!diff[WIDTH]) acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else              acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// MIPS EX-stage multiply/divide sequencer owning HI/LO; stalls the pipeline while a result is pending.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_con_start,
  input  logic [2:0]       i_con_op,
  input  logic [WIDTH-1:0] i_data_rs,
  input  logic [WIDTH-1:0] i_data_rt,
  input  logic             i_con_hilo_rd,
  output logic             o_con_busy,
  output logic             o_con_stall,
  output logic [WIDTH-1:0] o_data_hi,
  output logic [WIDTH-1:0] o_data_lo
);

  state_e             state, state_next;
  op_e                op;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc, acc_next;
  logic [WIDTH-1:0]   operand;
  logic               sign_a, sign_b, is_div, div_zero;
  logic [WIDTH-1:0]   hi, lo;

  logic               op_signed, op_is_div, rt_zero;
  logic [WIDTH-1:0]   mag_rs, mag_rt;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  assign op        = op_e'(i_con_op);
  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign op_is_div = (op == OP_DIV) || (op == OP_DIVU);
  assign rt_zero   = (i_data_rt == '0);
  assign mag_rs    = (op_signed && i_data_rs[WIDTH-1]) ? -i_data_rs : i_data_rs;
  assign mag_rt    = (op_signed && i_data_rt[WIDTH-1]) ? -i_data_rt : i_data_rt;

  assign prod_fix  = (sign_a ^ sign_b) ? -acc : acc;
  assign quot_fix  = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix   = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  assign o_con_busy  = (state != IDLE);
  assign o_con_stall = o_con_busy & (i_con_start | i_con_hilo_rd);
  assign o_data_hi   = hi;
  assign o_data_lo   = lo;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div_mode (is_div),
    .acc      (acc),
    .operand  (operand),
    .acc_next (acc_next)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (i_con_start) begin
          case (op)
            OP_MULT, OP_MULTU: state_next = MUL;
            OP_DIV, OP_DIVU:   state_next = rt_zero ? FIX : DIV;
            default:           state_next = IDLE;
          endcase
        end
      end
      MUL, DIV: if (cnt == CNT_W'(WIDTH - 1)) state_next = FIX;
      FIX:      state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt      <= '0;
      acc      <= '0;
      operand  <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      is_div   <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_con_start) begin
            if (op == OP_MTHI) hi <= i_data_rs;
            if (op == OP_MTLO) lo <= i_data_rs;
            if (op == OP_MULT || op == OP_MULTU || op_is_div) begin
              cnt      <= '0;
              operand  <= mag_rt;
              sign_a   <= op_signed & i_data_rs[WIDTH-1];
              sign_b   <= op_signed & i_data_rt[WIDTH-1];
              is_div   <= op_is_div;
              div_zero <= op_is_div & rt_zero;
              // Divide by zero skips iteration; raw rs parks in the upper half for HI.
              acc      <= (op_is_div && rt_zero) ? {i_data_rs, {WIDTH{1'b0}}}
                                                 : {{WIDTH{1'b0}}, mag_rs};
            end
          end
        end
        MUL, DIV: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          if (div_zero) begin
            hi <= acc[2*WIDTH-1:WIDTH];
            lo <= '1;
          end else if (is_div) begin
            hi <= rem_fix;
            lo <= quot_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
